// File: rtl/clock_pkg.sv
// Shared constants for the clock time-setting path: FSM state encoding,
// edited-field codes and per-field maximum values.
package clock_pkg;

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_SET_HOUR = 3'd1;
  localparam logic [2:0] ST_SET_MIN  = 3'd2;
  localparam logic [2:0] ST_SET_SEC  = 3'd3;
  localparam logic [2:0] ST_COMMIT   = 3'd4;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  function automatic logic is_set_state(input logic [2:0] st);
    return (st == ST_SET_HOUR) || (st == ST_SET_MIN) || (st == ST_SET_SEC);
  endfunction

  function automatic logic [1:0] field_of(input logic [2:0] st);
    case (st)
      ST_SET_HOUR: return FIELD_HOUR;
      ST_SET_MIN:  return FIELD_MIN;
      ST_SET_SEC:  return FIELD_SEC;
      default:     return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, live-time and load/status signals between the time-setting
// controller and its surroundings (buttons, counter chain, display).
interface clock_set_ctrl_if #(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5
);
  logic                  i_tick;
  logic                  i_mode;
  logic                  i_inc;
  logic                  i_dec;
  logic                  i_cancel;
  logic [P_SEC_BIT-1:0]  i_sec;
  logic [P_MIN_BIT-1:0]  i_min;
  logic [P_HOUR_BIT-1:0] i_hour;
  logic                  o_run_en;
  logic                  o_load;
  logic [P_SEC_BIT-1:0]  o_load_sec;
  logic [P_MIN_BIT-1:0]  o_load_min;
  logic [P_HOUR_BIT-1:0] o_load_hour;
  logic [1:0]            o_field;
  logic                  o_blink;

  modport master (
    output i_tick, i_mode, i_inc, i_dec, i_cancel, i_sec, i_min, i_hour,
    input  o_run_en, o_load, o_load_sec, o_load_min, o_load_hour, o_field, o_blink
  );

  modport slave (
    input  i_tick, i_mode, i_inc, i_dec, i_cancel, i_sec, i_min, i_hour,
    output o_run_en, o_load, o_load_sec, o_load_min, o_load_hour, o_field, o_blink
  );
endinterface

// File: rtl/mod_updown.sv
// One shadow time field: loadable (out-of-range loads clamp to 0) and
// stepped up/down with wrap-around between 0 and P_MAX.
module mod_updown #(
  parameter int P_WIDTH = 6,
  parameter int P_MAX   = 59
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld,
  input  logic [P_WIDTH-1:0] ld_val,
  input  logic               inc,
  input  logic               dec,
  output logic [P_WIDTH-1:0] val_o
);

  localparam logic [P_WIDTH-1:0] MAX_V = P_WIDTH'(P_MAX);

  logic [P_WIDTH-1:0] val_q, val_d;

  // NOTE: every path assigns val_d through the default first, so no latch is inferred.
  always_comb begin
    val_d = val_q;
    if (ld) begin
      val_d = (ld_val > MAX_V) ? '0 : ld_val;
    end else if (inc && !dec) begin
      val_d = (val_q == MAX_V) ? '0 : val_q + 1'b1;
    end else if (dec && !inc) begin
      val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) val_q <= '0;
    else       val_q <= val_d;
  end

  assign val_o = val_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks hour/min/sec editing, gates the counter
// chain while editing and commits the shadow time with a one-cycle load.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5,
  parameter int P_TIMEOUT  = 30,
  parameter int P_TO_BIT   = 5
) (
  input logic              clk,
  input logic              reset,
  clock_set_ctrl_if.slave  bus
);

  localparam logic [P_TO_BIT-1:0] TO_LAST = P_TO_BIT'(P_TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic [P_TO_BIT-1:0] to_q, to_d;
  logic                blink_q, blink_d;
  logic                load_q, load_d;
  logic                run_en_q, run_en_d;
  logic [1:0]          field_q, field_d;

  logic in_set, capture, step_ok, activity;

  assign in_set   = is_set_state(state_q);
  assign capture  = (state_q == ST_RUN) && bus.i_mode;
  // Field steps are suppressed when cancel or mode win the same cycle.
  assign step_ok  = in_set && !bus.i_cancel && !bus.i_mode;
  assign activity = bus.i_mode || bus.i_inc || bus.i_dec;

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    case (state_q)
      ST_RUN: begin
        to_d = '0;
        if (bus.i_mode) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        if (activity)        to_d = '0;
        else if (bus.i_tick) to_d = to_q + 1'b1;

        if (bus.i_cancel) begin
          state_d = ST_RUN;
        end else if (bus.i_mode) begin
          case (state_q)
            ST_SET_HOUR: state_d = ST_SET_MIN;
            ST_SET_MIN:  state_d = ST_SET_SEC;
            default:     state_d = ST_COMMIT;
          endcase
        end else if (!activity && bus.i_tick && (to_q == TO_LAST)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        to_d    = '0;
        state_d = ST_RUN;
      end
    endcase
    if (state_d == ST_RUN) to_d = '0;
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    run_en_d = (state_d == ST_RUN);
    load_d   = (state_d == ST_COMMIT);
    field_d  = field_of(state_d);
    blink_d  = 1'b0;
    if (is_set_state(state_d) && in_set) blink_d = blink_q ^ bus.i_tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      to_q     <= '0;
      blink_q  <= 1'b0;
      load_q   <= 1'b0;
      run_en_q <= 1'b1;
      field_q  <= FIELD_NONE;
    end else begin
      state_q  <= state_d;
      to_q     <= to_d;
      blink_q  <= blink_d;
      load_q   <= load_d;
      run_en_q <= run_en_d;
      field_q  <= field_d;
    end
  end

  mod_updown #(.P_WIDTH(P_HOUR_BIT), .P_MAX(HOUR_MAX)) u_hour (
    .clk    (clk),
    .reset  (reset),
    .ld     (capture),
    .ld_val (bus.i_hour),
    .inc    (step_ok && (state_q == ST_SET_HOUR) && bus.i_inc),
    .dec    (step_ok && (state_q == ST_SET_HOUR) && bus.i_dec),
    .val_o  (bus.o_load_hour)
  );

  mod_updown #(.P_WIDTH(P_MIN_BIT), .P_MAX(MIN_MAX)) u_min (
    .clk    (clk),
    .reset  (reset),
    .ld     (capture),
    .ld_val (bus.i_min),
    .inc    (step_ok && (state_q == ST_SET_MIN) && bus.i_inc),
    .dec    (step_ok && (state_q == ST_SET_MIN) && bus.i_dec),
    .val_o  (bus.o_load_min)
  );

  mod_updown #(.P_WIDTH(P_SEC_BIT), .P_MAX(SEC_MAX)) u_sec (
    .clk    (clk),
    .reset  (reset),
    .ld     (capture),
    .ld_val (bus.i_sec),
    .inc    (step_ok && (state_q == ST_SET_SEC) && bus.i_inc),
    .dec    (step_ok && (state_q == ST_SET_SEC) && bus.i_dec),
    .val_o  (bus.o_load_sec)
  );

  assign bus.o_run_en = run_en_q;
  assign bus.o_load   = load_q;
  assign bus.o_field  = field_q;
  assign bus.o_blink  = blink_q;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the hour/minute/second clock. It sequences the user through editing hour, minute and second, then commits the edited time to the counters with a single-cycle load strobe. It sits between the debounced button inputs and the sec/min/hour generator chain. It gates the chain's run enable while editing, and it owns the shadow time registers that are committed back to the counters.

## Interface
Parameters:
- P_SEC_BIT, 6, second field width
- P_MIN_BIT, 6, minute field width
- P_HOUR_BIT, 5, hour field width
- P_TIMEOUT, 30, number of i_tick pulses with no button activity before an edit is abandoned
- P_TO_BIT, 5, timeout counter width; must satisfy 2^P_TO_BIT > P_TIMEOUT

Ports:
- clk, input, 1, system clock; single clock domain. Reset is synchronous and active-high.
- reset, input, 1, synchronous active-high reset
- i_tick, input, 1, free-running one-second pulse (one clk wide), not gated by o_run_en
- i_mode, input, 1, debounced single-cycle pulse: enter edit / advance field / commit
- i_inc, input, 1, debounced single-cycle pulse: increment current field
- i_dec, input, 1, debounced single-cycle pulse: decrement current field
- i_cancel, input, 1, single-cycle pulse: abandon edit without loading
- i_sec, input, P_SEC_BIT, live second count
- i_min, input, P_MIN_BIT, live minute count
- i_hour, input, P_HOUR_BIT, live hour count
- o_run_en, output, 1, enable to the generator chain; 1 only in RUN
- o_load, output, 1, one-cycle strobe; counters take o_load_* when it is high
- o_load_sec, output, P_SEC_BIT, shadow second value
- o_load_min, output, P_MIN_BIT, shadow minute value
- o_load_hour, output, P_HOUR_BIT, shadow hour value
- o_field, output, 2, field being edited: 0 = none, 1 = hour, 2 = min, 3 = sec
- o_blink, output, 1, display blink phase; 0 in RUN

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN:
  - o_run_en=1.
  - i_mode captures i_hour/i_min/i_sec into the shadow registers and moves to SET_HOUR.
  - A captured value above its maximum (hour >23, min/sec >59) is stored as 0.
  - i_inc, i_dec and i_cancel are ignored.
- SET_x:
  - i_inc: shadow field +1, wrapping max→0.
  - i_dec: shadow field −1, wrapping 0→max.
  - Maximums: hour 23, min 59, sec 59.
  - i_mode: SET_HOUR→SET_MIN→SET_SEC→COMMIT.
- COMMIT: lasts one cycle, o_load=1, then RUN.
- Priority within a SET state, same cycle: i_cancel > i_mode > i_inc/i_dec. If i_inc and i_dec arrive together, no change.
- i_cancel in any SET state returns to RUN with no load.
- Timeout counter:
  - Cleared on entry to SET_HOUR and on any of i_mode/i_inc/i_dec.
  - Incremented on i_tick while in a SET state.
  - Reaching P_TIMEOUT returns to RUN with no load.
- o_blink toggles on each i_tick in SET states. It is forced to 0 in RUN/COMMIT and on SET_HOUR entry.
- o_load_* always drive the shadow registers.

## Timing
- All outputs are registered.
- Reset values:
  - state RUN, o_run_en=1
  - o_load=0, o_load_*=0
  - o_field=0, o_blink=0
  - timeout counter 0
- Reset has priority over every input. A mid-edit reset returns to RUN without a load.
- i_mode in RUN at cycle n:
  - Shadows capture the values present at cycle n.
  - At n+1: o_run_en=0 and o_field=1.
  - A tick coinciding with cycle n is lost from the counters. The one-second skew is accepted.
- i_inc/i_dec at cycle n: shadow value updated at n+1.
- i_mode in SET_SEC at n:
  - At n+1: o_load=1 and o_field=0, with o_run_en still 0.
  - At n+2: o_load=0 and o_run_en=1.
- Abort (cancel or timeout) at n: RUN and o_run_en=1 at n+1, with o_load never asserted.
- Input pulses arriving during COMMIT are ignored.

## Structure
- Shared package clock_pkg holds:
  - state encoding
  - field codes FIELD_NONE/HOUR/MIN/SEC
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23
- Sub-module mod_updown holds one shadow field:
  - parameters width and max
  - inputs ld, ld_val, inc, dec
  - behaviour: wrap-around, clamp on load
  - instantiated three times
- FSM, timeout counter and blink stay in clock_set_ctrl.

## Test plan
- Reset mid-SET_MIN → next cycle: state RUN, o_run_en=1, o_load=0, o_field=0.
- Live time 23:59:58, i_mode → o_field=1 one cycle later, o_load_hour=23. Then i_inc → o_load_hour=0. Then i_dec → o_load_hour=23.
- Full edit:
  - Enter edit, i_dec on min 0 → 59, i_mode ×3.
  - Required: o_load high for exactly one cycle with 59 on o_load_min, then o_run_en=1 one cycle later.
- Simultaneous pulses in SET_SEC:
  - i_inc+i_dec in the same cycle → shadow unchanged.
  - i_mode+i_inc in the same cycle → advance to COMMIT, sec unchanged.
  - i_cancel+i_mode in the same cycle → RUN with no o_load.
- Timeout with P_TIMEOUT=3:
  - In SET_MIN, 3 i_tick pulses with no buttons → RUN with no load.
  - An i_inc after the 2nd tick restarts the count.
  - o_blink toggles on each tick.
- Captured i_sec=63 → o_load_sec=0; i_inc → 1.
